// File: rtl/commit_unit_if.sv
// Commit-stage bundle: ROB head, store-buffer handshake, register-file write port,
// flush/redirect and architectural state outputs of commit_unit.
interface commit_unit_if;
  logic        rob_valid;
  logic [31:0] rob_PC;
  logic [31:0] rob_value;
  logic [4:0]  rob_rd;
  logic [31:0] rob_addr_miss;
  logic [2:0]  rob_exc;
  logic [2:0]  rob_inst_type;
  logic        sb_ready;
  logic        rob_pop;
  logic        sb_commit;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        flush;
  logic [31:0] redirect_PC;
  logic [31:0] rm0;
  logic [31:0] rm1;
  logic [31:0] rm2;
  logic        priv;
  logic [31:0] perf_retired;
  logic [31:0] perf_exc;

  // Commit-unit side.
  modport master (
    input  rob_valid, rob_PC, rob_value, rob_rd, rob_addr_miss, rob_exc, rob_inst_type,
           sb_ready,
    output rob_pop, sb_commit, rf_we, rf_rd, rf_data, flush, redirect_PC, rm0, rm1, rm2,
           priv, perf_retired, perf_exc
  );

  // ROB / pipeline side.
  modport slave (
    output rob_valid, rob_PC, rob_value, rob_rd, rob_addr_miss, rob_exc, rob_inst_type,
           sb_ready,
    input  rob_pop, sb_commit, rf_we, rf_rd, rf_data, flush, redirect_PC, rm0, rm1, rm2,
           priv, perf_retired, perf_exc
  );
endinterface

// File: rtl/commit_unit.sv
// In-order retirement stage: one ROB head per cycle, precise exceptions and IRET via flush.
// Optional retire/exception counters are built only when COMMIT_PERF_CNT_EN is defined.
module commit_unit #(
  parameter logic [31:0] EXC_HANDLER_ADDR = 32'h0000_2000,
  parameter int unsigned FLUSH_CYCLES     = 2
) (
  input  logic          clk,
  input  logic          reset,
  commit_unit_if.master bus
);

  localparam logic [2:0] TyLoad  = 3'd1;
  localparam logic [2:0] TyStore = 3'd2;
  localparam logic [2:0] TyMul   = 3'd4;
  localparam logic [2:0] TyIret  = 3'd5;

  localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(FLUSH_CYCLES - 1);

  typedef enum logic {StRun, StFlush} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [31:0]     rf_data_q, rf_data_d;
  logic            flush_q, flush_d;
  logic [31:0]     redirect_q, redirect_d;
  logic [31:0]     rm0_q, rm0_d;
  logic [31:0]     rm1_q, rm1_d;
  logic [1:0]      cause_q, cause_d;
  logic            priv_q, priv_d;

  logic       has_exc;
  logic       is_store;
  logic       is_iret;
  logic       writes_rd;
  logic       pop;
  logic [1:0] cause;

  always_comb begin
    has_exc  = |bus.rob_exc;
    is_store = (bus.rob_inst_type == TyStore);
    is_iret  = (bus.rob_inst_type == TyIret);
    // Types 6 and 7 retire as ALU ops.
    writes_rd = !(is_store || is_iret || bus.rob_inst_type == 3'd3);
    if (bus.rob_exc[0]) begin
      cause = 2'd1;
    end else if (bus.rob_exc[1]) begin
      cause = 2'd2;
    end else begin
      cause = 2'd3;
    end
  end

  // A faulting store never waits on the store buffer: it only needs to be squashed.
  assign pop = (state_q == StRun) && bus.rob_valid && (!is_store || has_exc || bus.sb_ready);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_data_d  = rf_data_q;
    flush_d    = flush_q;
    redirect_d = redirect_q;
    rm0_d      = rm0_q;
    rm1_d      = rm1_q;
    cause_d    = cause_q;
    priv_d     = priv_q;
    unique case (state_q)
      StRun: begin
        if (pop) begin
          if (has_exc) begin
            rm0_d      = bus.rob_PC;
            rm1_d      = bus.rob_addr_miss;
            cause_d    = cause;
            priv_d     = 1'b1;
            flush_d    = 1'b1;
            redirect_d = EXC_HANDLER_ADDR;
            cnt_d      = CntLoad;
            state_d    = StFlush;
          end else if (is_iret) begin
            priv_d     = 1'b0;
            flush_d    = 1'b1;
            redirect_d = rm0_q;
            cnt_d      = CntLoad;
            state_d    = StFlush;
          end else if (writes_rd && bus.rob_rd != 5'd0) begin
            rf_we_d   = 1'b1;
            rf_rd_d   = bus.rob_rd;
            rf_data_d = bus.rob_value;
          end
        end
      end
      StFlush: begin
        if (cnt_q == '0) begin
          flush_d = 1'b0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_data_q  <= 32'd0;
      flush_q    <= 1'b0;
      redirect_q <= 32'd0;
      rm0_q      <= 32'd0;
      rm1_q      <= 32'd0;
      cause_q    <= 2'd0;
      priv_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_data_q  <= rf_data_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      rm0_q      <= rm0_d;
      rm1_q      <= rm1_d;
      cause_q    <= cause_d;
      priv_q     <= priv_d;
    end
  end

  assign bus.rob_pop     = pop;
  assign bus.sb_commit   = pop && is_store && !has_exc;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_rd       = rf_rd_q;
  assign bus.rf_data     = rf_data_q;
  assign bus.flush       = flush_q;
  assign bus.redirect_PC = redirect_q;
  assign bus.rm0         = rm0_q;
  assign bus.rm1         = rm1_q;
  assign bus.rm2         = {30'd0, cause_q};
  assign bus.priv        = priv_q;

`ifdef COMMIT_PERF_CNT_EN
  logic [31:0] perf_ret_q;
  logic [31:0] perf_exc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_ret_q <= 32'd0;
      perf_exc_q <= 32'd0;
    end else if (pop) begin
      if (has_exc) begin
        perf_exc_q <= perf_exc_q + 32'd1;
      end else begin
        perf_ret_q <= perf_ret_q + 32'd1;
      end
    end
  end

  assign bus.perf_retired = perf_ret_q;
  assign bus.perf_exc     = perf_exc_q;
`else
  assign bus.perf_retired = 32'd0;
  assign bus.perf_exc     = 32'd0;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural retirement model.
module tb_commit_unit;

  localparam logic [31:0] Handler = 32'h0000_2000;
  localparam int          Flush   = 2;
`ifdef COMMIT_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  commit_unit_if bus ();

  commit_unit #(
    .EXC_HANDLER_ADDR (Handler),
    .FLUSH_CYCLES     (Flush)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: architectural state plus the number of flush cycles still owed.
  int          m_flush_left;
  logic        m_priv;
  logic [31:0] m_rm0, m_rm1, m_rm2, m_redirect;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] m_ret, m_exc;

  task automatic model_reset();
    m_flush_left = 0;
    m_priv       = 1'b1;
    m_rm0        = '0;
    m_rm1        = '0;
    m_rm2        = '0;
    m_redirect   = '0;
    m_we         = 1'b0;
    m_rd         = '0;
    m_data       = '0;
    m_ret        = '0;
    m_exc        = '0;
  endtask

  // Compare at the falling edge, then advance the model over the coming rising edge.
  always @(negedge clk) begin
    if (reset) begin
      model_reset();
    end else begin
      logic exp_pop, exp_sbc;
      logic [2:0] ty;
      ty      = bus.rob_inst_type;
      exp_pop = bus.rob_valid && (m_flush_left == 0) &&
                (ty != 3'd2 || bus.rob_exc != 3'd0 || bus.sb_ready);
      exp_sbc = exp_pop && ty == 3'd2 && bus.rob_exc == 3'd0;
      chk("rob_pop", bus.rob_pop, exp_pop);
      chk("sb_commit", bus.sb_commit, exp_sbc);
      chk("rf_we", bus.rf_we, m_we);
      if (m_we) begin
        chk("rf_rd", bus.rf_rd, m_rd);
        chk("rf_data", bus.rf_data, m_data);
      end
      chk("flush", bus.flush, m_flush_left > 0);
      if (m_flush_left > 0) chk("redirect_PC", bus.redirect_PC, m_redirect);
      chk("rm0", bus.rm0, m_rm0);
      chk("rm1", bus.rm1, m_rm1);
      chk("rm2", bus.rm2, m_rm2);
      chk("priv", bus.priv, m_priv);
      chk("perf_retired", bus.perf_retired, m_ret);
      chk("perf_exc", bus.perf_exc, m_exc);

      m_we = 1'b0;
      if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (exp_pop) begin
        if (bus.rob_exc != 3'd0) begin
          m_rm0        = bus.rob_PC;
          m_rm1        = bus.rob_addr_miss;
          m_rm2        = bus.rob_exc[0] ? 32'd1 : (bus.rob_exc[1] ? 32'd2 : 32'd3);
          m_priv       = 1'b1;
          m_redirect   = Handler;
          m_flush_left = Flush;
          if (PerfEn) m_exc = m_exc + 32'd1;
        end else begin
          if (PerfEn) m_ret = m_ret + 32'd1;
          if (ty == 3'd5) begin
            m_redirect   = m_rm0;
            m_priv       = 1'b0;
            m_flush_left = Flush;
          end else if (ty != 3'd2 && ty != 3'd3 && bus.rob_rd != 5'd0) begin
            m_we   = 1'b1;
            m_rd   = bus.rob_rd;
            m_data = bus.rob_value;
          end
        end
      end
    end
  end

  task automatic set_in(input logic v, input logic [2:0] ty, input logic [31:0] pc,
                        input logic [31:0] val, input logic [4:0] rd, input logic [31:0] addr,
                        input logic [2:0] exc, input logic sbr);
    bus.rob_valid     = v;
    bus.rob_inst_type = ty;
    bus.rob_PC        = pc;
    bus.rob_value     = val;
    bus.rob_rd        = rd;
    bus.rob_addr_miss = addr;
    bus.rob_exc       = exc;
    bus.sb_ready      = sbr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 32'd0, 3'd0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle();
    repeat (3) tick();
    chk("reset rf_we", bus.rf_we, 32'd0);
    chk("reset rf_rd", bus.rf_rd, 32'd0);
    chk("reset rf_data", bus.rf_data, 32'd0);
    chk("reset flush", bus.flush, 32'd0);
    chk("reset redirect", bus.redirect_PC, 32'd0);
    chk("reset rm0", bus.rm0, 32'd0);
    chk("reset rm2", bus.rm2, 32'd0);
    chk("reset priv", bus.priv, 32'd1);
    chk("reset perf_retired", bus.perf_retired, 32'd0);
    reset = 1'b0;

    // ALU write-back appears the cycle after the pop.
    set_in(1'b1, 3'd0, 32'h40, 32'hDEAD_BEEF, 5'd5, 32'd0, 3'd0, 1'b0);
    #1 chk("t1 pop", bus.rob_pop, 32'd1);
    tick();
    chk("t1 rf_we", bus.rf_we, 32'd1);
    chk("t1 rf_rd", bus.rf_rd, 32'd5);
    chk("t1 rf_data", bus.rf_data, 32'hDEAD_BEEF);

    // Store stalls on sb_ready.
    set_in(1'b1, 3'd2, 32'h44, 32'h1, 5'd3, 32'd0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t2 stall pop", bus.rob_pop, 32'd0);
      chk("t2 stall sb_commit", bus.sb_commit, 32'd0);
      tick();
    end
    bus.sb_ready = 1'b1;
    #1 chk("t2 pop", bus.rob_pop, 32'd1);
    chk("t2 sb_commit", bus.sb_commit, 32'd1);
    tick();
    chk("t2 rf_we", bus.rf_we, 32'd0);

    // dTLB + illegal on a load: lowest set bit wins, cause 2.
    set_in(1'b1, 3'd1, 32'h100, 32'h5, 5'd4, 32'h8000, 3'b110, 1'b1);
    #1 chk("t3 pop", bus.rob_pop, 32'd1);
    chk("t3 sb_commit", bus.sb_commit, 32'd0);
    tick();
    chk("t3 rm0", bus.rm0, 32'h100);
    chk("t3 rm1", bus.rm1, 32'h8000);
    chk("t3 rm2", bus.rm2, 32'd2);
    chk("t3 priv", bus.priv, 32'd1);
    chk("t3 flush", bus.flush, 32'd1);
    chk("t3 redirect", bus.redirect_PC, Handler);
    chk("t3 rf_we", bus.rf_we, 32'd0);
    set_in(1'b1, 3'd5, 32'h300, 32'd0, 5'd0, 32'd0, 3'd0, 1'b1);
    #1 chk("t3 no pop in flush", bus.rob_pop, 32'd0);
    tick();
    chk("t3 flush 2nd", bus.flush, 32'd1);
    #1 chk("t3 no pop 2nd", bus.rob_pop, 32'd0);
    tick();
    chk("t3 flush done", bus.flush, 32'd0);

    // IRET returns to rm0 in user mode.
    #1 chk("t4 pop", bus.rob_pop, 32'd1);
    tick();
    idle();
    chk("t4 flush", bus.flush, 32'd1);
    chk("t4 redirect", bus.redirect_PC, 32'h100);
    chk("t4 priv", bus.priv, 32'd0);

    // Reset mid-flush.
    #2 reset = 1'b1;
    #1 chk("t5 reset flush", bus.flush, 32'd0);
    chk("t5 reset priv", bus.priv, 32'd1);
    tick();
    reset = 1'b0;
    set_in(1'b1, 3'd0, 32'h500, 32'h1234, 5'd0, 32'd0, 3'd0, 1'b0);
    #1 chk("t5 pop rd0", bus.rob_pop, 32'd1);
    tick();
    chk("t5 rf_we rd0", bus.rf_we, 32'd0);

    // Nine more ALU ops (ten since reset), then one exception.
    set_in(1'b1, 3'd6, 32'h600, 32'h77, 5'd7, 32'd0, 3'd0, 1'b0);
    repeat (9) tick();
    set_in(1'b1, 3'd3, 32'h700, 32'd0, 5'd0, 32'h9000, 3'b001, 1'b0);
    tick();
    idle();
    chk("t6 perf_retired", bus.perf_retired, PerfEn ? 32'd10 : 32'd0);
    chk("t6 perf_exc", bus.perf_exc, PerfEn ? 32'd1 : 32'd0);
    chk("t6 rm2 itlb", bus.rm2, 32'd1);
    repeat (3) tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      logic [2:0] exc;
      exc = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      set_in(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom, $urandom,
             5'($urandom_range(0, 31)), $urandom, exc, ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      tick();
      reset = 1'b0;
    end
    idle();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
